mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-port memory between the CPU's instruction-fetch port and its load/store port. It serialises the two requesters with a registered round-robin grant and drives a request/ready handshake toward memory. It returns read data to the granted requester with a one-cycle ready pulse, and stalls the other requester by holding its ready low. It sits between the CPU core and the memory model or bus bridge.

## Interface
Parameters:
- `TIMEOUT`, 255: memory-wait cycles before a transaction is aborted (only with `ARB_TIMEOUT_EN`); 1..65535.
- `ADDR_W`, 32: address width.

Ports:
- `i_clk` in 1: clock; all state updates on the rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_if_req` in 1: fetch request; held until `o_if_ready`.
- `i_if_addr` in ADDR_W: fetch address.
- `o_if_ready` out 1: one-cycle completion pulse for fetch.
- `o_if_rdata` out 32: fetched word; valid while `o_if_ready`.
- `i_d_req` in 1: data request; held until `o_d_ready`.
- `i_d_we` in 1: 1 = store.
- `i_d_addr` in ADDR_W: data address.
- `i_d_wdata` in 32: store data.
- `i_d_size` in 2: size code; 01 byte, 10 half, 11 word, 00 none.
- `o_d_ready` out 1: one-cycle completion pulse for data.
- `o_d_rdata` out 32: load data, raw word, no extension.
- `o_mem_req` out 1: memory request; held until `i_mem_ready`.
- `o_mem_we`, `o_mem_addr`, `o_mem_wdata`, `o_mem_size` out 1/ADDR_W/32/2: registered command.
- `i_mem_ready` in 1: memory completion; sampled only while `o_mem_req` = 1.
- `i_mem_rdata` in 32: valid when `i_mem_ready` = 1.
- `o_err` out 1: one-cycle timeout pulse.

## Operation
- The FSM has states IDLE, BUSY, and DONE. A registered `gnt` bit selects the owner: 0 = fetch, 1 = data. A registered `last` bit records the last owner.
- **IDLE:**
  - If only one requester asserts its request, it is granted.
  - If both request, the one not equal to `last` is granted.
  - On grant, the command registers load. A fetch loads `we` = 0 and `size` = 11.
  - The FSM goes to BUSY and `o_mem_req` becomes 1.
- **Data no-op:** a data request with `i_d_size` = 00 goes IDLE→DONE directly. It makes no memory access and returns `o_d_rdata` = 0.
- **BUSY:**
  - `o_mem_req` and the command registers are held stable.
  - On `i_mem_ready` = 1: `i_mem_rdata` is captured into the granted rdata register, `o_mem_req` drops, `last` ← `gnt`, and the FSM goes to DONE.
- **DONE:**
  - The granted ready output is 1 for exactly this cycle.
  - Both requests are ignored.
  - The next state is always IDLE.
- **Stall:** the non-granted requester sees ready = 0 and must hold its request and address.
- **Reset:** `i_rst` asserted at any time, including mid-BUSY, acts immediately.
  - State → IDLE and `last` → 1, so fetch wins the first tie.
  - Every output → 0, including `o_mem_req`, all rdata outputs, and `o_err`.
  - An in-flight transaction is abandoned; memory must tolerate `o_mem_req` dropping.

## Timing
- **Minimum latency:**
  - A request is high in cycle 0 and sampled at edge 1.
  - `o_mem_req` is high in cycle 1; if `i_mem_ready` = 1 in cycle 1, it is captured at edge 2.
  - Ready is high in cycle 2.
  - IDLE is reached in cycle 3, where new requests are sampled.
- **Throughput:** at most one transfer per 3 cycles. Every added memory wait cycle adds one cycle of latency.
- **Registered outputs:** all outputs are registered; there is no combinational path from any input to any output.
- **Memory-side ready:** `i_mem_ready` in IDLE or DONE is ignored.
- **Requester behaviour after completion:** a requester that keeps its request high after ready is treated as a new request in IDLE.

## Configuration
- Macro `ARB_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit wait counter clears on entry to BUSY and increments each BUSY cycle without `i_mem_ready`.
  - When the count reaches `TIMEOUT`, the transaction aborts: `o_mem_req` drops, the FSM goes to DONE, the granted rdata = 0, the ready pulse is issued, and `o_err` = 1 for the DONE cycle.
  - `i_mem_ready` arriving in the same cycle as the timeout wins: the transaction completes normally and `o_err` stays 0.
- **Undefined:** BUSY waits indefinitely, and `o_err` is tied to 0.

## Structure
- Package `mem_pkg` holds:
  - the `arb_state_t` enum (IDLE, BUSY, DONE);
  - `memsize_t` and the constants `MS_NONE` = 00, `MS_BYTE` = 01, `MS_HALF` = 10, `MS_WORD` = 11;
  - `GNT_IF` = 0 and `GNT_D` = 1.
- Sub-module `arb_timer` is the wait counter with a compare against `TIMEOUT`. It is instantiated only under `ARB_TIMEOUT_EN`.

## Test plan
- **Reset:** assert `i_rst` mid-BUSY → all outputs 0 within the same cycle. After release, a tie of both requests grants fetch first.
- **Single fetch:** `i_if_addr` = 0x100, memory ready in 0 wait cycles with rdata = 0xDEADBEEF → `o_mem_req` high for 1 cycle with `o_mem_addr` = 0x100 and `o_mem_size` = 11. Then `o_if_ready` pulses one cycle later with `o_if_rdata` = 0xDEADBEEF; `o_d_ready` stays 0.
- **Contention:** both requests held for 4 transfers → grant order is IF, D, IF, D. A store of 0x12345678 with size 01 appears on memory with `o_mem_we` = 1.
- **Wait states and no-op:** memory ready after 3 wait cycles → ready arrives at cycle 5 and the command is stable throughout BUSY. A data request with size 00 → `o_d_ready` at cycle 1 with no `o_mem_req`.
- **Timeout (`ARB_TIMEOUT_EN`, `TIMEOUT` = 4):** memory never ready → `o_mem_req` drops after 4 BUSY cycles, the ready pulse comes with rdata = 0, and `o_err` = 1 for one cycle.
- **Timeout collision:** `i_mem_ready` in the same cycle as the count reaches `TIMEOUT` → normal completion and `o_err` = 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef logic [1:0] memsize_t;

  localparam memsize_t MS_NONE = 2'b00;
  localparam memsize_t MS_BYTE = 2'b01;
  localparam memsize_t MS_HALF = 2'b10;
  localparam memsize_t MS_WORD = 2'b11;

  // Grant encoding: which requester owns the memory port.
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

endpackage

// File: rtl/arb_timer.sv
// Memory-wait counter: counts BUSY cycles without a memory ready and flags
// the cycle in which the wait budget would be exhausted.
module arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_busy,
  input  logic i_ready,
  output logic o_expire
);

  // Expire fires in the TIMEOUT-th wait cycle so the FSM leaves BUSY on
  // that edge; a ready in the same cycle takes priority.
  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] cnt;

  // Wait counter: cleared outside BUSY, bumped on every unanswered BUSY cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                   cnt <= '0;
    else if (i_clear)            cnt <= '0;
    else if (i_busy && !i_ready) cnt <= cnt + 16'd1;
  end

  assign o_expire = i_busy & ~i_ready & (cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction
// fetch and load/store. All outputs are registered.
// Optional feature: define ARB_TIMEOUT_EN to abort memory waits after
// TIMEOUT cycles (ready pulse with zero data plus an o_err pulse).
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ready,
  output logic [31:0]       o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [31:0]       i_d_wdata,
  input  logic [1:0]        i_d_size,
  output logic              o_d_ready,
  output logic [31:0]       o_d_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [1:0]        o_mem_size,
  input  logic              i_mem_ready,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_err
);

  arb_state_t        state, state_n;
  logic              gnt, gnt_n;
  logic              last, last_n;
  logic              pick;
  logic              expire;
  logic              req_n, we_n, if_ready_n, d_ready_n, err_n;
  logic [ADDR_W-1:0] addr_n;
  logic [31:0]       wdata_n, if_rdata_n, d_rdata_n;
  memsize_t          size_n;

`ifdef ARB_TIMEOUT_EN
  arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (state != BUSY),
    .i_busy  (state == BUSY),
    .i_ready (i_mem_ready),
    .o_expire(expire)
  );
`else
  // Without the timer BUSY waits forever; TMO_VALID keeps TIMEOUT referenced.
  localparam logic TMO_VALID = (TIMEOUT >= 1) && (TIMEOUT <= 65535);
  assign expire = 1'b0 & TMO_VALID;
`endif

  // State, grant history and every output register; reset clears all outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      gnt         <= GNT_IF;
      last        <= GNT_D;   // fetch wins the first tie
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_size  <= MS_NONE;
      o_if_ready  <= 1'b0;
      o_if_rdata  <= '0;
      o_d_ready   <= 1'b0;
      o_d_rdata   <= '0;
      o_err       <= 1'b0;
    end else begin
      state       <= state_n;
      gnt         <= gnt_n;
      last        <= last_n;
      o_mem_req   <= req_n;
      o_mem_we    <= we_n;
      o_mem_addr  <= addr_n;
      o_mem_wdata <= wdata_n;
      o_mem_size  <= size_n;
      o_if_ready  <= if_ready_n;
      o_if_rdata  <= if_rdata_n;
      o_d_ready   <= d_ready_n;
      o_d_rdata   <= d_rdata_n;
      o_err       <= err_n;
    end
  end

  // Next-state and next-output logic; registers hold unless a transition loads them.
  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    last_n     = last;
    req_n      = o_mem_req;
    we_n       = o_mem_we;
    addr_n     = o_mem_addr;
    wdata_n    = o_mem_wdata;
    size_n     = o_mem_size;
    if_ready_n = 1'b0;
    d_ready_n  = 1'b0;
    if_rdata_n = o_if_rdata;
    d_rdata_n  = o_d_rdata;
    err_n      = 1'b0;
    // On a tie the requester that did not own the port last time wins.
    pick       = (i_if_req && i_d_req) ? ~last : i_d_req;

    unique case (state)
      IDLE: begin
        if (i_if_req || i_d_req) begin
          gnt_n = pick;
          if (pick == GNT_D && i_d_size == MS_NONE) begin
            // No-op access completes without touching memory. It still
            // counts as a data turn so fetch cannot be starved by no-ops.
            state_n   = DONE;
            d_ready_n = 1'b1;
            d_rdata_n = '0;
            last_n    = GNT_D;
          end else begin
            state_n = BUSY;
            req_n   = 1'b1;
            if (pick == GNT_D) begin
              we_n    = i_d_we;
              addr_n  = i_d_addr;
              wdata_n = i_d_wdata;
              size_n  = i_d_size;
            end else begin
              we_n    = 1'b0;
              addr_n  = i_if_addr;
              wdata_n = '0;
              size_n  = MS_WORD;
            end
          end
        end
      end
      BUSY: begin
        // Ready beats a simultaneous timeout; expire only acts without ready.
        if (i_mem_ready || expire) begin
          state_n = DONE;
          req_n   = 1'b0;
          last_n  = gnt;
          err_n   = ~i_mem_ready;
          if (gnt == GNT_D) begin
            d_ready_n = 1'b1;
            d_rdata_n = i_mem_ready ? i_mem_rdata : 32'd0;
          end else begin
            if_ready_n = 1'b1;
            if_rdata_n = i_mem_ready ? i_mem_rdata : 32'd0;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard of expected completions,
// background memory responder with programmable wait states.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_if_req, i_d_req, i_d_we, i_mem_ready;
  logic [ADDR_W-1:0] i_if_addr, i_d_addr;
  logic [31:0]       i_d_wdata, i_mem_rdata;
  logic [1:0]        i_d_size;
  logic              o_if_ready, o_d_ready, o_mem_req, o_mem_we, o_err;
  logic [31:0]       o_if_rdata, o_d_rdata, o_mem_wdata;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [1:0]        o_mem_size;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(4), .ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_ready(o_if_ready), .o_if_rdata(o_if_rdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr),
    .i_d_wdata(i_d_wdata), .i_d_size(i_d_size),
    .o_d_ready(o_d_ready), .o_d_rdata(o_d_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_size(o_mem_size),
    .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata),
    .o_err(o_err)
  );

  typedef struct packed {
    logic        port;   // 0 fetch, 1 data
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
  } cmd_t;

  exp_t sb[$];
  cmd_t cmd_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mem_wait = 0;
  bit   mem_auto = 1'b0;
  int   wcnt = 0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: answers after mem_wait unanswered request cycles.
  initial begin
    i_mem_ready = 1'b0;
    i_mem_rdata = 32'hFFFF_FFFF;
    forever begin
      @(negedge clk);
      if (o_mem_req === 1'b1) begin
        if (mem_auto && wcnt >= mem_wait) begin
          i_mem_ready = 1'b1;
          i_mem_rdata = mdata(o_mem_addr);
          cmd_q.push_back('{o_mem_we, o_mem_addr, o_mem_wdata, o_mem_size});
        end else begin
          i_mem_ready = 1'b0;
          i_mem_rdata = 32'hFFFF_FFFF;
          wcnt++;
        end
      end else begin
        i_mem_ready = 1'b0;
        i_mem_rdata = 32'hFFFF_FFFF;
        wcnt = 0;
      end
    end
  end

  task automatic test_reset();
    exp_t e;
    i_if_req = 0; i_d_req = 0; i_d_we = 0; i_if_addr = '0; i_d_addr = '0;
    i_d_wdata = '0; i_d_size = MS_NONE;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_if_ready, o_if_rdata, o_d_ready, o_d_rdata, o_mem_req, o_mem_we, o_mem_addr,
         o_mem_wdata, o_mem_size, o_err} !== '0) begin
      errors++; $display("FAIL reset_init: outputs not all zero (mem_req=%b if_ready=%b)", o_mem_req, o_if_ready);
    end
    rst = 1'b0; mem_auto = 1'b0; i_if_req = 1; i_if_addr = 32'h80;
    repeat (3) @(negedge clk);
    checks++;
    if (o_mem_req !== 1'b1) begin
      errors++; $display("FAIL busy_before_reset: mem_req got %b want 1", o_mem_req);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({o_if_ready, o_if_rdata, o_d_ready, o_d_rdata, o_mem_req, o_mem_we, o_mem_addr,
         o_mem_wdata, o_mem_size, o_err} !== '0) begin
      errors++; $display("FAIL reset_mid_busy: mem_req=%b addr=%h size=%b want all zero", o_mem_req, o_mem_addr, o_mem_size);
    end
    @(negedge clk);
    rst = 1'b0; mem_auto = 1'b1; mem_wait = 0;
    i_if_req = 1; i_if_addr = 32'h104;
    i_d_req = 1; i_d_addr = 32'h204; i_d_size = MS_WORD; i_d_we = 0;
    sb.push_back('{GNT_IF, mdata(32'h104), 1'b0});
    for (int c = 0; c < 10 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (o_if_ready || o_d_ready) begin
        e = sb.pop_front();
        checks++;
        if (o_d_ready !== e.port || o_if_rdata !== e.rdata) begin
          errors++; $display("FAIL reset_tie: d_ready=%b if_rdata=%h want port=%b rdata=%h", o_d_ready, o_if_rdata, e.port, e.rdata);
        end
        i_if_req = 0; i_d_req = 0;
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL reset_tie_timeout: %0d completions outstanding want 0", sb.size()); sb.delete();
    end
    i_if_req = 0; i_d_req = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_fetch();
    exp_t e;
    mem_auto = 1'b1; mem_wait = 0;
    i_if_req = 1; i_if_addr = 32'h100;
    sb.push_back('{GNT_IF, 32'hDEADBEEF, 1'b0});
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h100 || o_mem_size !== MS_WORD || o_mem_we !== 1'b0) begin
          errors++; $display("FAIL fetch_cmd: req=%b addr=%h size=%b we=%b want 1 00000100 11 0", o_mem_req, o_mem_addr, o_mem_size, o_mem_we);
        end
      end else if (c == 2) begin
        checks++;
        if (o_mem_req !== 1'b0 || o_d_ready !== 1'b0) begin
          errors++; $display("FAIL fetch_req_drop: mem_req=%b d_ready=%b want 0 0", o_mem_req, o_d_ready);
        end
        checks++;
        if (o_if_ready !== 1'b1) begin
          errors++; $display("FAIL fetch_ready: if_ready got %b want 1", o_if_ready); sb.delete();
        end else begin
          e = sb.pop_front();
          checks++;
          if (o_if_rdata !== e.rdata) begin
            errors++; $display("FAIL fetch_rdata: got %h want %h", o_if_rdata, e.rdata);
          end
        end
        i_if_req = 0;
      end else begin
        checks++;
        if (o_if_ready !== 1'b0) begin
          errors++; $display("FAIL fetch_pulse_width: if_ready got %b want 0", o_if_ready);
        end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_contention();
    exp_t e;
    cmd_t got, want;
    cmd_t ec[$];
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    sb.delete(); cmd_q.delete();
    mem_auto = 1'b1; mem_wait = 0;
    i_if_req = 1; i_if_addr = 32'h40;
    i_d_req = 1; i_d_we = 1; i_d_addr = 32'h200; i_d_wdata = 32'h12345678; i_d_size = MS_BYTE;
    sb.push_back('{GNT_IF, mdata(32'h40),  1'b0});  ec.push_back('{1'b0, 32'h40,  32'h0,        MS_WORD});
    sb.push_back('{GNT_D,  mdata(32'h200), 1'b0});  ec.push_back('{1'b1, 32'h200, 32'h12345678, MS_BYTE});
    sb.push_back('{GNT_IF, mdata(32'h44),  1'b0});  ec.push_back('{1'b0, 32'h44,  32'h0,        MS_WORD});
    sb.push_back('{GNT_D,  mdata(32'h204), 1'b0});  ec.push_back('{1'b0, 32'h204, 32'h0,        MS_WORD});
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (o_if_ready || o_d_ready) begin
        e = sb.pop_front();
        want = ec.pop_front();
        checks++;
        if (o_d_ready !== e.port || o_if_ready !== ~e.port) begin
          errors++; $display("FAIL contention_order: if_ready=%b d_ready=%b want port %b", o_if_ready, o_d_ready, e.port);
        end
        checks++;
        if ((e.port ? o_d_rdata : o_if_rdata) !== e.rdata) begin
          errors++; $display("FAIL contention_rdata: got %h want %h", e.port ? o_d_rdata : o_if_rdata, e.rdata);
        end
        checks++;
        if (cmd_q.size() == 0) begin
          errors++; $display("FAIL contention_cmd: no memory command seen want addr %h", want.addr);
        end else begin
          got = cmd_q.pop_front();
          if (got !== want) begin
            errors++; $display("FAIL contention_cmd: got we=%b addr=%h wdata=%h size=%b want we=%b addr=%h wdata=%h size=%b",
                               got.we, got.addr, got.wdata, got.size, want.we, want.addr, want.wdata, want.size);
          end
        end
        if (o_if_ready) i_if_addr = i_if_addr + 32'd4;
        if (o_d_ready) begin
          i_d_we = 0; i_d_addr = 32'h204; i_d_wdata = 32'h0; i_d_size = MS_WORD;
        end
        if (sb.size() == 0) begin i_if_req = 0; i_d_req = 0; end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL contention_timeout: %0d transfers outstanding want 0", sb.size()); sb.delete();
    end
    i_if_req = 0; i_d_req = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wait_noop();
    exp_t e;
    cmd_t snap;
    mem_auto = 1'b1; mem_wait = 3;
    i_if_req = 1; i_if_addr = 32'h300;
    sb.push_back('{GNT_IF, mdata(32'h300), 1'b0});
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) snap = '{o_mem_we, o_mem_addr, o_mem_wdata, o_mem_size};
      if (c <= 4) begin
        checks++;
        if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h300 ||
            snap !== cmd_t'{o_mem_we, o_mem_addr, o_mem_wdata, o_mem_size}) begin
          errors++; $display("FAIL wait_cmd_stable: cycle %0d req=%b addr=%h want 1 00000300", c, o_mem_req, o_mem_addr);
        end
      end
      checks++;
      if (o_if_ready !== (c == 5)) begin
        errors++; $display("FAIL wait_ready_cycle: cycle %0d if_ready=%b want %b", c, o_if_ready, c == 5);
      end
      if (c == 5 && o_if_ready && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (o_if_rdata !== e.rdata) begin
          errors++; $display("FAIL wait_rdata: got %h want %h", o_if_rdata, e.rdata);
        end
        i_if_req = 0;
      end
    end
    sb.delete(); i_if_req = 0; mem_wait = 0;
    @(negedge clk);
    i_d_req = 1; i_d_we = 0; i_d_size = MS_NONE; i_d_addr = 32'h400;
    @(negedge clk);
    checks++;
    if (o_d_ready !== 1'b1 || o_d_rdata !== 32'h0 || o_mem_req !== 1'b0) begin
      errors++; $display("FAIL noop: d_ready=%b d_rdata=%h mem_req=%b want 1 00000000 0", o_d_ready, o_d_rdata, o_mem_req);
    end
    i_d_req = 0;
    @(negedge clk);
    checks++;
    if (o_d_ready !== 1'b0 || o_mem_req !== 1'b0) begin
      errors++; $display("FAIL noop_after: d_ready=%b mem_req=%b want 0 0", o_d_ready, o_mem_req);
    end
    repeat (2) @(negedge clk);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    mem_auto = 1'b0;
    i_if_req = 1; i_if_addr = 32'h500;
    sb.push_back('{GNT_IF, 32'h0, 1'b1});
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (o_mem_req !== (c <= 4) || o_err !== (c == 5) || o_if_ready !== (c == 5)) begin
        errors++; $display("FAIL timeout_seq: cycle %0d req=%b err=%b ready=%b want %b %b %b",
                           c, o_mem_req, o_err, o_if_ready, c <= 4, c == 5, c == 5);
      end
      if (c == 5 && o_if_ready && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (o_if_rdata !== e.rdata) begin
          errors++; $display("FAIL timeout_rdata: got %h want %h", o_if_rdata, e.rdata);
        end
        i_if_req = 0;
      end
    end
    sb.delete(); i_if_req = 0;
    @(negedge clk);
    mem_auto = 1'b1; mem_wait = 3;
    i_if_req = 1; i_if_addr = 32'h504;
    sb.push_back('{GNT_IF, mdata(32'h504), 1'b0});
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (o_err !== 1'b0 || o_if_ready !== (c == 5)) begin
        errors++; $display("FAIL timeout_collision: cycle %0d err=%b ready=%b want 0 %b", c, o_err, o_if_ready, c == 5);
      end
      if (c == 5 && o_if_ready && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (o_if_rdata !== e.rdata) begin
          errors++; $display("FAIL collision_rdata: got %h want %h", o_if_rdata, e.rdata);
        end
        i_if_req = 0;
      end
    end
    sb.delete(); i_if_req = 0; mem_wait = 0;
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_wait_noop();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
